axis_acdc_combiner: RTL and testbench

AXIS_ACDC_COMBINER -- requirements
Module: axis_acdc_combiner

---
 rtl/rpspmc_acdc_pkg.sv | 51 +++++
 rtl/axis_skid_buffer.sv | 73 +++++++
 rtl/axis_acdc_combiner.sv | 180 ++++++++++++++++++
 tb/tb_axis_acdc_combiner.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpspmc_acdc_pkg.sv
// Shared definitions for the AC/DC combiner: FSM state encoding, the bit
// layout of the packed {dc, ac} stream word, and the Q15 clamp limits.
package rpspmc_acdc_pkg;

    localparam int ACDC_HALF_W = 16;

    // Packed input word layout: {dc[31:16], ac[15:0]}
    localparam int DC_MSB = 31;
    localparam int DC_LSB = 16;
    localparam int AC_MSB = 15;
    localparam int AC_LSB = 0;

    localparam logic [ACDC_HALF_W-1:0] Q15_MAX = 16'h7FFF;
    localparam logic [ACDC_HALF_W-1:0] Q15_MIN = 16'h8000;

    // Legacy-compatible fixed encoding; state_dbg exposes it directly.
    typedef logic [1:0] acdc_state_t;
    localparam acdc_state_t ST_IDLE  = 2'd0;
    localparam acdc_state_t ST_PRIME = 2'd1;
    localparam acdc_state_t ST_RUN   = 2'd2;
    localparam acdc_state_t ST_DRAIN = 2'd3;

    function automatic logic [ACDC_HALF_W-1:0] acdc_dc(input logic [DC_MSB:0] word);
        return word[DC_MSB:DC_LSB];
    endfunction

    function automatic logic [ACDC_HALF_W-1:0] acdc_ac(input logic [DC_MSB:0] word);
        return word[AC_MSB:AC_LSB];
    endfunction

    function automatic logic [DC_MSB:0] acdc_pack(input logic [ACDC_HALF_W-1:0] dc,
                                                  input logic [ACDC_HALF_W-1:0] ac);
        logic [DC_MSB:0] word;
        word = '0;
        word[DC_MSB:DC_LSB] = dc;
        word[AC_MSB:AC_LSB] = ac;
        return word;
    endfunction

    // Clamp a 17-bit two's-complement sum into the Q15 range.
    function automatic logic [ACDC_HALF_W-1:0] q15_clamp(input logic [ACDC_HALF_W:0] sum);
        if (sum[ACDC_HALF_W] == sum[ACDC_HALF_W-1]) begin
            return sum[ACDC_HALF_W-1:0];
        end else if (sum[ACDC_HALF_W]) begin
            return Q15_MIN;
        end else begin
            return Q15_MAX;
        end
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: an output register plus one skid slot.
// s_tready_o comes straight from the skid-slot flag, so upstream ready never
// depends combinationally on m_tready_i.
module axis_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_tdata_i,
    input  logic             s_tvalid_i,
    output logic             s_tready_o,
    output logic [WIDTH-1:0] m_tdata_o,
    output logic             m_tvalid_o,
    input  logic             m_tready_i
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             s_fire;
    logic             out_free;

    assign s_tready_o = !skid_valid_q;
    assign s_fire     = s_tvalid_i && !skid_valid_q;
    assign out_free   = !out_valid_q || m_tready_i;

    // Next-state: refill the output register from the skid slot first (older
    // beat), else from the input; park the input in the skid slot on a stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (s_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = s_tdata_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (s_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_tdata_i;
        end
    end

    // State registers for both slots.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            // NOTE: data registers are reset as well so tdata reads 0 straight out of reset.
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign m_tvalid_o = out_valid_q;
    assign m_tdata_o  = out_data_q;

endmodule

// File: rtl/axis_acdc_combiner.sv
// AC/DC combiner: adds the signed DC and AC halves of each packed input beat
// (or a manual DC value) and streams the Q15 result out. After enable the
// first PRIME_SAMPLES beats are discarded while the upstream DC filter settles.
// Build option: define AXIS_ACDC_COMBINER_SAT_EN to clamp overflowing sums to
// Q15 limits and count them in sat_count; otherwise sums wrap and sat_count=0.
module axis_acdc_combiner
    import rpspmc_acdc_pkg::*;
#(
    parameter int DATA_WIDTH    = ACDC_HALF_W,
    parameter int PRIME_SAMPLES = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DC_MSB:0]       S_AXIS_ACDC_tdata,
    input  logic                  S_AXIS_ACDC_tvalid,
    output logic                  S_AXIS_ACDC_tready,
    input  logic                  enable,
    input  logic                  dc_manual_sel,
    input  logic [DATA_WIDTH-1:0] dc_manual,
    output logic [DATA_WIDTH-1:0] M_AXIS_SIGNAL_tdata,
    output logic                  M_AXIS_SIGNAL_tvalid,
    input  logic                  M_AXIS_SIGNAL_tready,
    output logic [15:0]           sat_count,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = (PRIME_SAMPLES < 2) ? 1 : $clog2(PRIME_SAMPLES + 1);
    localparam logic [CNT_W-1:0] PRIME_LOAD = CNT_W'(PRIME_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    acdc_state_t           state_q, state_d;
    logic [CNT_W-1:0]      prime_cnt_q, prime_cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH:0]   s1_sum_q, s1_sum_d;
    logic [DATA_WIDTH-1:0] dc_sel;
    logic [DATA_WIDTH-1:0] ac_half;
    logic [DATA_WIDTH-1:0] out_word;
    logic                  sb_s_tready;
    logic                  in_ready;
    logic                  in_fire;
    logic                  s1_load;
    logic                  s1_fwd;
    logic                  run_start;

    // Input ready uses only registered state: FSM state and the skid-slot flag.
    // While the skid slot is free, stage 1 always drains, so it can take a beat.
    assign in_ready  = (state_q == ST_PRIME) || ((state_q == ST_RUN) && sb_s_tready);
    assign in_fire   = S_AXIS_ACDC_tvalid && in_ready;
    assign s1_load   = in_fire && (state_q == ST_RUN);
    assign s1_fwd    = s1_valid_q && sb_s_tready;
    assign run_start = (state_q == ST_IDLE) && enable;

    assign dc_sel  = dc_manual_sel ? dc_manual : acdc_dc(S_AXIS_ACDC_tdata);
    assign ac_half = acdc_ac(S_AXIS_ACDC_tdata);

    // FSM next-state and prime counter.
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    prime_cnt_d = PRIME_LOAD;
                    state_d     = (PRIME_SAMPLES == 0) ? ST_RUN : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!enable) begin
                    // Abandoning the settling window; nothing is in flight yet.
                    state_d     = ST_IDLE;
                    prime_cnt_d = '0;
                end else if (in_fire) begin
                    prime_cnt_d = prime_cnt_q - CNT_ONE;
                    if (prime_cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave only once stage 1, the output register and the skid slot are empty.
                if (!s1_valid_q && !M_AXIS_SIGNAL_tvalid && sb_s_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            prime_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    // Stage 1 next-state: hold on a stall, empty on forward, load on a RUN beat.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        if (s1_fwd) begin
            s1_valid_d = 1'b0;
        end
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = {dc_sel[DATA_WIDTH-1], dc_sel} + {ac_half[DATA_WIDTH-1], ac_half};
        end
    end

    // Stage 1 registers: full-precision 17-bit sum.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
        end
    end

`ifdef AXIS_ACDC_COMBINER_SAT_EN
    logic        sat_hit;
    logic [15:0] sat_count_q, sat_count_d;

    assign sat_hit  = s1_sum_q[DATA_WIDTH] != s1_sum_q[DATA_WIDTH-1];
    assign out_word = q15_clamp(s1_sum_q);

    // Saturation counter: cleared on enable rise, counts clamped samples, sticks at max.
    always_comb begin
        sat_count_d = sat_count_q;
        if (run_start) begin
            sat_count_d = '0;
        end else if (s1_fwd && sat_hit && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    logic unused_sum_msb;

    assign unused_sum_msb = s1_sum_q[DATA_WIDTH] ^ run_start;
    assign out_word       = s1_sum_q[DATA_WIDTH-1:0];
    assign sat_count      = '0;
`endif

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH)
    ) u_out_slice (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tdata_i  (out_word),
        .s_tvalid_i (s1_valid_q),
        .s_tready_o (sb_s_tready),
        .m_tdata_o  (M_AXIS_SIGNAL_tdata),
        .m_tvalid_o (M_AXIS_SIGNAL_tvalid),
        .m_tready_i (M_AXIS_SIGNAL_tready)
    );

    assign S_AXIS_ACDC_tready = in_ready;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_axis_acdc_combiner.sv
// Directed bench for axis_acdc_combiner (default parameters). Expected values
// follow the AXIS_ACDC_COMBINER_SAT_EN build option when it is defined.
module tb_axis_acdc_combiner;
    import rpspmc_acdc_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        enable;
    logic        dc_manual_sel;
    logic [15:0] dc_manual;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] sat_count;
    logic [1:0]  state_dbg;

    always #5 aclk = ~aclk;

    axis_acdc_combiner #(
        .DATA_WIDTH    (16),
        .PRIME_SAMPLES (4)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .S_AXIS_ACDC_tdata    (s_tdata),
        .S_AXIS_ACDC_tvalid   (s_tvalid),
        .S_AXIS_ACDC_tready   (s_tready),
        .enable               (enable),
        .dc_manual_sel        (dc_manual_sel),
        .dc_manual            (dc_manual),
        .M_AXIS_SIGNAL_tdata  (m_tdata),
        .M_AXIS_SIGNAL_tvalid (m_tvalid),
        .M_AXIS_SIGNAL_tready (m_tready),
        .sat_count            (sat_count),
        .state_dbg            (state_dbg)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data = '0;

    // Random-test working variables.
    logic [15:0] r_dc, r_ac, r_man;
    logic        r_sel, r_acc;
    int          r_accepted, r_cycles, r_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Reference sum: signed add, then clamp (SAT build) or wrap.
    function automatic logic [15:0] model_sum(input logic [15:0] dc, input logic [15:0] ac);
        int s;
        s = int'($signed(dc)) + int'($signed(ac));
`ifdef AXIS_ACDC_COMBINER_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    function automatic bit model_sat(input logic [15:0] dc, input logic [15:0] ac);
        int s;
        s = int'($signed(dc)) + int'($signed(ac));
`ifdef AXIS_ACDC_COMBINER_SAT_EN
        return (s > 32767) || (s < -32768);
`else
        return 1'b0;
`endif
    endfunction

    // Output monitor: records handshakes and checks stalled outputs hold still.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {31'd0, m_tvalid}, 32'd1);
                check("stall_data", {16'd0, m_tdata}, {16'd0, stall_data});
            end
            if (m_tvalid && m_tready) got_q.push_back(m_tdata);
            stall_prev <= m_tvalid && !m_tready;
            stall_data <= m_tdata;
        end
    end

    task automatic send(input logic [15:0] dc, input logic [15:0] ac,
                        input logic sel, input logic [15:0] man);
        logic acc;
        acc           = 1'b0;
        s_tdata       = acdc_pack(dc, ac);
        dc_manual_sel = sel;
        dc_manual     = man;
        s_tvalid      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            acc = s_tready;
            tick();
            if (acc) break;
        end
        s_tvalid = 1'b0;
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    // Enable and feed throw-away (saturating) beats through the prime window.
    task automatic start_run();
        enable        = 1'b1;
        s_tdata       = acdc_pack(16'h7FFF, 16'h7FFF);
        dc_manual_sel = 1'b0;
        s_tvalid      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state_dbg == ST_RUN) break;
        end
        s_tvalid = 1'b0;
        check("prime_done", {30'd0, state_dbg}, {30'd0, ST_RUN});
        check("prime_no_out", got_q.size(), 0);
    endtask

    task automatic stop_run();
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (state_dbg == ST_IDLE) break;
            tick();
        end
        check("back_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) break;
            tick();
        end
        check("out_count", got_q.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        s_tdata       = '0;
        s_tvalid      = 1'b0;
        enable        = 1'b0;
        dc_manual_sel = 1'b0;
        dc_manual     = '0;
        m_tready      = 1'b1;

        // Reset values
        #2;
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_s_tready", {31'd0, s_tready}, 32'd0);
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_m_tdata", {16'd0, m_tdata}, 32'd0);
        check("rst_sat", {16'd0, sat_count}, 32'd0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        tick();
        check("idle_no_enable", {30'd0, state_dbg}, 32'd0);

        // Prime discards 4 beats, then two 0x0110 outputs, two cycles after acceptance
        got_q.delete();
        enable = 1'b1;
        tick();
        check("t1_prime", {30'd0, state_dbg}, {30'd0, ST_PRIME});
        check("t1_prime_rdy", {31'd0, s_tready}, 32'd1);
        s_tdata  = acdc_pack(16'h0100, 16'h0010);
        s_tvalid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t1_vld", {31'd0, m_tvalid}, (i == 6) ? 32'd1 : 32'd0);
            if (i == 4) check("t1_run", {30'd0, state_dbg}, {30'd0, ST_RUN});
        end
        check("t1_data0", {16'd0, m_tdata}, 32'h0110);
        s_tvalid = 1'b0;
        tick();
        check("t1_vld_b", {31'd0, m_tvalid}, 32'd1);
        check("t1_data1", {16'd0, m_tdata}, 32'h0110);
        tick();
        check("t1_vld_end", {31'd0, m_tvalid}, 32'd0);
        check("t1_count", got_q.size(), 2);
        stop_run();

        // Overflow in both directions
        got_q.delete();
        start_run();
        send(16'h7000, 16'h2000, 1'b0, 16'h0000);
        send(16'h9000, 16'hE000, 1'b0, 16'h0000);
        wait_out(2, 50);
        stop_run();
`ifdef AXIS_ACDC_COMBINER_SAT_EN
        check("ovf_pos", {16'd0, got_q[0]}, 32'h7FFF);
        check("ovf_neg", {16'd0, got_q[1]}, 32'h8000);
        check("ovf_sat", {16'd0, sat_count}, 32'd2);
`else
        check("ovf_pos", {16'd0, got_q[0]}, 32'h9000);
        check("ovf_neg", {16'd0, got_q[1]}, 32'h7000);
        check("ovf_sat", {16'd0, sat_count}, 32'd0);
`endif

        // Manual DC override, sampled per beat
        got_q.delete();
        start_run();
        send(16'h1234, 16'h0200, 1'b1, 16'hFF00);
        send(16'h0300, 16'h0005, 1'b0, 16'hFF00);
        wait_out(2, 50);
        check("man_dc", {16'd0, got_q[0]}, 32'h0100);
        check("stream_dc", {16'd0, got_q[1]}, 32'h0305);
        stop_run();

        // Drain with two beats in flight under backpressure
        got_q.delete();
        start_run();
        m_tready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0, 16'h0000);
        send(16'h0010, 16'h0020, 1'b0, 16'h0000);
        enable = 1'b0;
        tick();
        check("drain_state", {30'd0, state_dbg}, {30'd0, ST_DRAIN});
        check("drain_rdy", {31'd0, s_tready}, 32'd0);
        enable = 1'b1;
        tick();
        tick();
        tick();
        check("drain_hold", {30'd0, state_dbg}, {30'd0, ST_DRAIN});
        check("drain_vld", {31'd0, m_tvalid}, 32'd1);
        check("drain_data", {16'd0, m_tdata}, 32'h0003);
        check("drain_none", got_q.size(), 0);
        enable   = 1'b0;
        m_tready = 1'b1;
        wait_out(2, 50);
        check("drain_d0", {16'd0, got_q[0]}, 32'h0003);
        check("drain_d1", {16'd0, got_q[1]}, 32'h0030);
        stop_run();

        // 1000 random beats, random input gaps and 50% downstream ready
        got_q.delete();
        exp_q.delete();
        start_run();
        r_accepted = 0;
        r_cycles   = 0;
        r_sat      = 0;
        while (r_accepted < 1000 && r_cycles < 20000) begin
            m_tready = 1'($urandom_range(0, 1));
            if (!s_tvalid && ($urandom_range(0, 3) != 0)) begin
                r_dc          = 16'($urandom);
                r_ac          = 16'($urandom);
                r_man         = 16'($urandom);
                r_sel         = ($urandom_range(0, 7) == 0);
                s_tdata       = acdc_pack(r_dc, r_ac);
                dc_manual     = r_man;
                dc_manual_sel = r_sel;
                s_tvalid      = 1'b1;
            end
            r_acc = s_tvalid && s_tready;
            tick();
            r_cycles++;
            if (r_acc) begin
                exp_q.push_back(model_sum(r_sel ? r_man : r_dc, r_ac));
                if (model_sat(r_sel ? r_man : r_dc, r_ac)) r_sat++;
                r_accepted++;
                s_tvalid = 1'b0;
            end
        end
        s_tvalid = 1'b0;
        check("rnd_accepted", r_accepted, 1000);
        m_tready = 1'b1;
        wait_out(exp_q.size(), 200);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("rnd_data", {16'd0, got_q[i]}, {16'd0, exp_q[i]});
        end
        check("rnd_sat", {16'd0, sat_count}, r_sat);
        stop_run();

        // Asynchronous reset mid-RUN with beats in flight
        got_q.delete();
        start_run();
        m_tready = 1'b0;
        send(16'h7000, 16'h2000, 1'b0, 16'h0000);
        send(16'h0001, 16'h0001, 1'b0, 16'h0000);
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
        check("mid_rst_s_tready", {31'd0, s_tready}, 32'd0);
        check("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("mid_rst_m_tdata", {16'd0, m_tdata}, 32'd0);
        check("mid_rst_sat", {16'd0, sat_count}, 32'd0);
        tick();
        tick();
        aresetn  = 1'b1;
        enable   = 1'b0;
        m_tready = 1'b1;
        s_tdata  = acdc_pack(16'h0100, 16'h0010);
        s_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_state", {30'd0, state_dbg}, 32'd0);
        check("post_rst_rdy", {31'd0, s_tready}, 32'd0);
        check("post_rst_vld", {31'd0, m_tvalid}, 32'd0);
        check("post_rst_none", got_q.size(), 0);
        s_tvalid = 1'b0;
        got_q.delete();
        start_run();
        send(16'h0100, 16'h0010, 1'b0, 16'h0000);
        wait_out(1, 50);
        check("post_rst_data", {16'd0, got_q[0]}, 32'h0110);
        stop_run();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
